// File: rtl/dit_frame_feeder_pkg.sv
// Shared types for the DIT frame feeder: sample packing, read FSM encoding, index width.
`timescale 1ns/1ps
package dit_frame_feeder_pkg;

    localparam int X_WDTH_DEF = 16;
    localparam int NLOG2_DEF  = 3;
    localparam int N_DEF      = 1 << NLOG2_DEF;
    localparam int IDX_W      = NLOG2_DEF;

    // Real part in the upper half, imaginary in the lower half.
    typedef logic [2*X_WDTH_DEF-1:0] cplx_t;
    typedef logic [IDX_W-1:0]        idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } rd_state_e;

    function automatic cplx_t cplx_pack(input logic [X_WDTH_DEF-1:0] re,
                                        input logic [X_WDTH_DEF-1:0] im);
        return {re, im};
    endfunction

endpackage

// File: rtl/dit_pingpong_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
`timescale 1ns/1ps
module dit_pingpong_ram
    import dit_frame_feeder_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/dit_frame_feeder.sv
// Ping-pong frame buffer that turns a bursty sample stream into gap-separated,
// bubble-free frames for the DIT FFT core.
`timescale 1ns/1ps
module dit_frame_feeder
    import dit_frame_feeder_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int NLOG2  = NLOG2_DEF,
    parameter int X_WDTH = X_WDTH_DEF,
    parameter int GAP    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2*X_WDTH-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [2*X_WDTH-1:0] din,
    output logic                din_nd,
    output logic                frame_start,
    output logic                busy
);

    localparam int STAGES = 2;
    localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [NLOG2-1:0] LAST_IDX = NLOG2'(N-1);

    logic [1:0]            full, full_nxt;
    logic                  wr_bank, rd_bank;
    logic [NLOG2-1:0]      wr_idx, rd_idx;
    logic                  wr_fire, wr_last, rd_en;
    rd_state_e             state;
    logic [GW-1:0]         gap_cnt;
    logic [STAGES:1]       vld_pipe;
    logic                  p1_first, p1_last, p1_bank;
    logic [2*X_WDTH-1:0]   rd_data;

    assign in_ready = !rst && !full[wr_bank];
    assign wr_fire  = in_valid && in_ready;
    assign wr_last  = wr_fire && (wr_idx == LAST_IDX);
    assign rd_en    = (state == ST_SEND) || (state == ST_IDLE && full[rd_bank]);
    assign din_nd   = vld_pipe[STAGES];
    assign busy     = (|full) || (wr_idx != '0) || (state != ST_IDLE) || (|vld_pipe);

    // Fill and release always target different banks, so both can land together.
    always_comb begin
        full_nxt = full;
        if (vld_pipe[1] && p1_last)
            full_nxt[p1_bank] = 1'b0;
        if (wr_last)
            full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
            full    <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                if (wr_last) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx  <= wr_idx + 1'b1;
                end
            end
        end
    end

    dit_pingpong_ram #(
        .AW (NLOG2 + 1),
        .DW (2*X_WDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr ({wr_bank, wr_idx}),
        .wdata (in_data),
        .re    (rd_en),
        .raddr ({rd_bank, rd_idx}),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rd_bank     <= 1'b0;
            rd_idx      <= '0;
            gap_cnt     <= '0;
            vld_pipe    <= '0;
            p1_first    <= 1'b0;
            p1_last     <= 1'b0;
            p1_bank     <= 1'b0;
            din         <= '0;
            frame_start <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], rd_en};
            if (rd_en) begin
                p1_first <= (rd_idx == '0);
                p1_last  <= (rd_idx == LAST_IDX);
                p1_bank  <= rd_bank;
            end
            if (vld_pipe[1]) begin
                din         <= rd_data;
                frame_start <= p1_first;
            end else begin
                frame_start <= 1'b0;
            end

            case (state)
                ST_IDLE, ST_SEND: begin
                    if (rd_en) begin
                        if (rd_idx == LAST_IDX) begin
                            rd_idx  <= '0;
                            rd_bank <= ~rd_bank;
                            gap_cnt <= '0;
                            // With no gap, chain straight into a bank completing this very edge.
                            if (GAP > 0)
                                state <= ST_GAP;
                            else
                                state <= full_nxt[~rd_bank] ? ST_SEND : ST_IDLE;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                            state  <= ST_SEND;
                        end
                    end
                end
                ST_GAP: begin
                    if (int'(gap_cnt) == GAP - 1)
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dit_frame_feeder.md
DIT_FRAME_FEEDER -- requirements
Module: dit_frame_feeder

Interface
REQ-001 Parameter N, default 8: FFT length in complex samples per frame.
REQ-002 Parameter NLOG2, default 3: log2(N), width of sample index counters.
REQ-003 Parameter X_WDTH, default 16: width of each real/imag component.
REQ-004 Parameter GAP, default 2: minimum idle cycles (din_nd low) between consecutive frames; 0 allows back-to-back frames.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_data  in  2*X_WDTH  upstream complex sample, real in upper X_WDTH bits, imag in lower.
REQ-008 in_valid  in  1  in_data valid this cycle.
REQ-009 in_ready  out  1  feeder can accept a sample this cycle.
REQ-010 din  out  2*X_WDTH  sample to dit, same packing as in_data.
REQ-011 din_nd  out  1  din valid this cycle (dit new-data strobe).
REQ-012 frame_start  out  1  high with the first sample (index 0) of each frame on din.
REQ-013 busy  out  1  high when any bank holds data or a frame is in transmission.

Function
REQ-014 A sample SHALL be accepted on each rising edge where in_valid and in_ready are both high; no other cycle writes.
REQ-015 Storage SHALL be two banks (ping-pong) of N words each; write side fills banks alternately starting at bank 0.
REQ-016 A bank SHALL be marked full on the edge accepting its sample index N-1; the write pointer then moves to the other bank.
REQ-017 in_ready SHALL be high exactly when the current write bank is not full.
REQ-018 Read FSM states: IDLE, SEND, GAP; IDLE->SEND when read bank full; SEND->GAP after index N-1 issued (GAP>0); SEND->SEND or IDLE directly when GAP=0; GAP->IDLE after GAP cycles.
REQ-019 Within SEND, samples SHALL be emitted on N consecutive cycles, index 0..N-1 in arrival order, din_nd high on each; no bubbles inside a frame.
REQ-020 Latency: with the FSM in IDLE, first din_nd of a frame SHALL occur 2 cycles after the edge accepting that frame's last sample (registered RAM read).
REQ-021 A read bank SHALL be released (not full) on the edge at which its index N-1 is presented on din; in_ready for that bank rises the following cycle if it is the write bank.
REQ-022 Simultaneous fill of one bank and release of the other in the same cycle SHALL both take effect; no sample lost or duplicated.
REQ-023 din SHALL hold its last value when din_nd is low; consumers must ignore it.
REQ-024 Frames SHALL be emitted strictly in fill order; partial frames SHALL never be emitted.
REQ-025 Counter wrap: write and read indices wrap N-1->0 with bank toggle; no other modulo behaviour.
REQ-026 in_valid while in_ready low SHALL be ignored, with no state change.

Reset
REQ-027 While rst high at an edge: din_nd=0, frame_start=0, din=0, busy=0, both banks empty, pointers to bank 0 index 0, FSM=IDLE, in_ready=0.
REQ-028 in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-029 Reset mid-frame SHALL discard all buffered and partially sent data; din_nd low from the first reset edge.

Structure
REQ-030 Shared package holds the complex-sample type (2*X_WDTH packing), FSM state encoding, and index width derived from NLOG2.
REQ-031 One sub-module, dit_pingpong_ram: 2N x 2*X_WDTH simple dual-port RAM, one write port, one registered read port.

Verification (N=8, GAP=2, X_WDTH=16)
REQ-032 Reset, then 8 samples 0x00010001..0x00080008 back-to-back -> din_nd high 8 consecutive cycles starting 2 cycles after the 8th accept, same order, frame_start with 0x00010001.
REQ-033 24 samples continuous in_valid -> three frames, each 8 din_nd cycles separated by exactly 2 idle cycles; in_ready drops only when both banks are full.
REQ-034 GAP=0, 16 continuous samples -> 16 consecutive din_nd cycles, frame_start at the 1st and 9th.
REQ-035 5 samples then idle for 50 cycles -> no din_nd; busy=1 throughout.
REQ-036 rst asserted during 4th sample of a sending frame -> din_nd low next cycle, in_ready=1 after release, next 8 samples emitted as a clean frame.
REQ-037 Random in_valid gaps (50% duty) over 10 frames -> output stream equals input stream, every frame contiguous.
